// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one OBI-style data memory port between two requesters.
//   Port 0 is the load/store unit and port 1 is instruction fetch.
//   The address phase is arbitrated round-robin. Once a request is shown
//   without a grant, it is locked so the address phase stays stable.
//   An in-order FIFO of issuer indices routes each response back to the
//   port that issued it.
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   req_i/gnt_o                    per-port address-phase handshake
//   addr_i/we_i/be_i/wdata_i       per-port request payload
//   rvalid_o/rdata_o               per-port response valid, shared response data
//   mem_req_o/mem_gnt_i            shared port address-phase handshake
//   mem_addr_o/we/be/wdata         payload muxed from the selected port
//   mem_rvalid_i/mem_rdata_i       shared port response
//   err_o                          sticky: response arrived with nothing outstanding
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTSTD = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [1:0]                 req_i,
  output logic [1:0]                 gnt_o,
  input  logic [1:0][DATA_WIDTH-1:0] addr_i,
  input  logic [1:0]                 we_i,
  input  logic [1:0][3:0]            be_i,
  input  logic [1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]                 rvalid_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       mem_req_o,
  input  logic                       mem_gnt_i,
  output logic [DATA_WIDTH-1:0]      mem_addr_o,
  output logic                       mem_we_o,
  output logic [3:0]                 mem_be_o,
  output logic [DATA_WIDTH-1:0]      mem_wdata_o,
  input  logic                       mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]      mem_rdata_i,
  output logic                       err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTD) + 1;
  localparam int unsigned PW = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MAX_OUTSTD-1:0] fifo_q, fifo_d;   // issuer index per outstanding slot
  logic                  rr_q, rr_d;
  logic                  lock_q, lock_d, lock_idx_q, lock_idx_d;
  logic                  err_q, err_d;

  logic sel, full, empty, hs, pop;

  always_comb begin
    full  = (count_q == CW'(MAX_OUTSTD));
    empty = (count_q == '0);

    if (lock_q)             sel = lock_idx_q;
    else if (req_i == 2'b11) sel = rr_q;
    else                    sel = req_i[1];

    // Outputs are forced low while reset is held, not only after the first edge.
    mem_req_o = rst_ni && (|req_i) && !full;
    hs        = mem_req_o && mem_gnt_i;
    pop       = rst_ni && mem_rvalid_i && !empty;

    gnt_o      = '0;
    gnt_o[sel] = hs;
    rvalid_o   = '0;
    rvalid_o[fifo_q[rptr_q]] = pop;
    rdata_o    = mem_rdata_i;

    mem_addr_o  = addr_i[sel];
    mem_we_o    = we_i[sel];
    mem_be_o    = be_i[sel];
    mem_wdata_o = wdata_i[sel];

    fifo_d  = fifo_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rr_d    = rr_q;
    if (hs) begin
      fifo_d[wptr_q] = sel;
      wptr_d = (wptr_q == PW'(MAX_OUTSTD - 1)) ? '0 : wptr_q + 1'b1;
      rr_d   = ~sel;
    end
    if (pop) rptr_d = (rptr_q == PW'(MAX_OUTSTD - 1)) ? '0 : rptr_q + 1'b1;
    count_d = count_q + CW'(hs) - CW'(pop);

    // A request stalled by the full FIFO is not visible on the bus, so the
    // lock neither sets nor clears then.
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (hs) begin
      lock_d = 1'b0;
    end else if (mem_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end

    err_d = err_q | (mem_rvalid_i && empty);
    err_o = err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_q     <= '0;
      rr_q       <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fifo_q     <= fifo_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int DW  = 32;
  localparam int MAX = 2;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [1:0]         req_i;
  logic [1:0]         gnt_o;
  logic [1:0][DW-1:0] addr_i;
  logic [1:0]         we_i;
  logic [1:0][3:0]    be_i;
  logic [1:0][DW-1:0] wdata_i;
  logic [1:0]         rvalid_o;
  logic [DW-1:0]      rdata_o;
  logic               mem_req_o;
  logic               mem_gnt_i;
  logic [DW-1:0]      mem_addr_o;
  logic               mem_we_o;
  logic [3:0]         mem_be_o;
  logic [DW-1:0]      mem_wdata_o;
  logic               mem_rvalid_i;
  logic [DW-1:0]      mem_rdata_i;
  logic               err_o;

  int n_chk = 0;
  int n_pass = 0;

  mem_port_arbiter #(.DATA_WIDTH(DW), .MAX_OUTSTD(MAX)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o),
    .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: list of outstanding issuers plus arbitration state.
  int q[$];
  int rr;
  bit lock;
  int lock_idx;
  bit m_err;
  int e_sel;
  bit e_mreq, e_hs;
  logic [1:0] e_gnt, e_rv;

  task automatic model_reset();
    q.delete(); rr = 0; lock = 0; lock_idx = 0; m_err = 0;
  endtask

  task automatic model_eval();
    if (lock) e_sel = lock_idx;
    else if (req_i == 2'b11) e_sel = rr;
    else e_sel = req_i[1] ? 1 : 0;
    e_mreq = (req_i != 2'b00) && (q.size() < MAX);
    e_hs   = e_mreq && mem_gnt_i;
    e_gnt  = e_hs ? 2'(1 << e_sel) : 2'b00;
    e_rv   = (mem_rvalid_i && q.size() > 0) ? 2'(1 << q[0]) : 2'b00;
  endtask

  task automatic model_update();
    if (mem_rvalid_i) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_err = 1;
    end
    if (e_hs) begin
      q.push_back(e_sel); rr = 1 - e_sel; lock = 0;
    end else if (e_mreq) begin
      lock = 1; lock_idx = e_sel;
    end
  endtask

  task automatic set_in(input logic [1:0] req, input logic gnt, input logic rv, input logic [DW-1:0] rd);
    req_i = req; mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rd;
  endtask

  task automatic next_cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic apply_reset();
    set_in(2'b00, 1'b0, 1'b0, '0);
    rst_ni = 1'b0;
    #12;
    rst_ni = 1'b1;
    next_cyc();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    set_in(2'b11, 1'b1, 1'b1, 32'h1234_5678);
    #3;
    n_chk++; if (mem_req_o !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_req_o); else n_pass++;
    n_chk++; if (gnt_o !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", gnt_o); else n_pass++;
    n_chk++; if (rvalid_o !== 2'b00) $display("FAIL reset_rvalid got=%b exp=00", rvalid_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_o); else n_pass++;
    set_in(2'b00, 1'b0, 1'b0, '0);
    #10;
    rst_ni = 1'b1;
    next_cyc();
  endtask

  task automatic test_single_read();
    apply_reset();
    set_in(2'b01, 1'b1, 1'b0, '0);
    @(negedge clk_i);
    n_chk++; if (gnt_o !== 2'b01) $display("FAIL t1_gnt got=%b exp=01", gnt_o); else n_pass++;
    n_chk++; if (mem_addr_o !== 32'h100) $display("FAIL t1_addr got=%h exp=100", mem_addr_o); else n_pass++;
    n_chk++; if (mem_we_o !== 1'b0 || mem_be_o !== 4'hF) $display("FAIL t1_we_be got=%b/%h exp=0/f", mem_we_o, mem_be_o); else n_pass++;
    next_cyc();
    set_in(2'b00, 1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clk_i);
    n_chk++; if (rvalid_o !== 2'b01) $display("FAIL t1_rvalid got=%b exp=01", rvalid_o); else n_pass++;
    n_chk++; if (rdata_o !== 32'hDEADBEEF) $display("FAIL t1_rdata got=%h exp=deadbeef", rdata_o); else n_pass++;
    next_cyc();
  endtask

  task automatic test_round_robin();
    logic [1:0] prev;
    apply_reset();
    prev = 2'b00;
    for (int c = 0; c < 6; c++) begin
      set_in(2'b11, 1'b1, c > 0, 32'hA000 + c);
      @(negedge clk_i);
      n_chk++; if (gnt_o !== ((c % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL t2_gnt cyc=%0d got=%b exp=%b", c, gnt_o, (c % 2 == 0) ? 2'b01 : 2'b10); else n_pass++;
      if (c > 0) begin
        n_chk++; if (rvalid_o !== prev) $display("FAIL t2_rvalid cyc=%0d got=%b exp=%b", c, rvalid_o, prev); else n_pass++;
      end
      prev = (c % 2 == 0) ? 2'b01 : 2'b10;
      next_cyc();
    end
  endtask

  task automatic test_lock();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      set_in((c == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0, '0);
      @(negedge clk_i);
      n_chk++; if (mem_addr_o !== 32'h200 || gnt_o !== 2'b00) $display("FAIL t3_lock cyc=%0d addr=%h gnt=%b exp=200/00", c, mem_addr_o, gnt_o); else n_pass++;
      next_cyc();
    end
    set_in(2'b11, 1'b1, 1'b0, '0);
    @(negedge clk_i);
    n_chk++; if (gnt_o !== 2'b10) $display("FAIL t3_gnt1 got=%b exp=10", gnt_o); else n_pass++;
    next_cyc();
    @(negedge clk_i);
    n_chk++; if (gnt_o !== 2'b01 || mem_addr_o !== 32'h100) $display("FAIL t3_gnt0 got=%b/%h exp=01/100", gnt_o, mem_addr_o); else n_pass++;
    next_cyc();
  endtask

  task automatic test_fifo_full();
    apply_reset();
    set_in(2'b11, 1'b1, 1'b0, '0);
    next_cyc(); next_cyc();
    @(negedge clk_i);
    n_chk++; if (mem_req_o !== 1'b0 || gnt_o !== 2'b00) $display("FAIL t4_full got=%b/%b exp=0/00", mem_req_o, gnt_o); else n_pass++;
    next_cyc();
    set_in(2'b11, 1'b1, 1'b1, 32'h5555);
    @(negedge clk_i);
    n_chk++; if (rvalid_o !== 2'b01) $display("FAIL t4_rvalid got=%b exp=01", rvalid_o); else n_pass++;
    n_chk++; if (mem_req_o !== 1'b0) $display("FAIL t4_full_pop got=%b exp=0", mem_req_o); else n_pass++;
    next_cyc();
    set_in(2'b11, 1'b1, 1'b0, '0);
    @(negedge clk_i);
    n_chk++; if (mem_req_o !== 1'b1 || gnt_o !== 2'b01) $display("FAIL t4_resume got=%b/%b exp=1/01", mem_req_o, gnt_o); else n_pass++;
    next_cyc();
  endtask

  task automatic test_err_and_reset();
    apply_reset();
    set_in(2'b00, 1'b0, 1'b1, 32'h77);
    @(negedge clk_i);
    n_chk++; if (rvalid_o !== 2'b00) $display("FAIL t5_stray_rv got=%b exp=00", rvalid_o); else n_pass++;
    next_cyc();
    set_in(2'b01, 1'b1, 1'b0, '0);
    @(negedge clk_i);
    n_chk++; if (err_o !== 1'b1) $display("FAIL t5_err_set got=%b exp=1", err_o); else n_pass++;
    next_cyc();
    set_in(2'b11, 1'b0, 1'b0, '0);
    @(negedge clk_i);
    n_chk++; if (err_o !== 1'b1) $display("FAIL t5_err_hold got=%b exp=1", err_o); else n_pass++;
    rst_ni = 1'b0;
    #1;
    n_chk++; if (err_o !== 1'b0 || mem_req_o !== 1'b0) $display("FAIL t5_rst got=%b/%b exp=0/0", err_o, mem_req_o); else n_pass++;
    #6;
    rst_ni = 1'b1;
    next_cyc();
    set_in(2'b11, 1'b0, 1'b1, '0);
    @(negedge clk_i);
    n_chk++; if (rvalid_o !== 2'b00 || mem_addr_o !== 32'h100) $display("FAIL t5_post_rst rv=%b addr=%h exp=00/100", rvalid_o, mem_addr_o); else n_pass++;
    next_cyc();
    set_in(2'b00, 1'b0, 1'b0, '0);
    @(negedge clk_i);
    n_chk++; if (err_o !== 1'b1) $display("FAIL t5_err_again got=%b exp=1", err_o); else n_pass++;
    next_cyc();
  endtask

  task automatic test_push_pop();
    apply_reset();
    set_in(2'b01, 1'b1, 1'b0, '0);
    next_cyc();
    set_in(2'b10, 1'b1, 1'b1, 32'h11);
    @(negedge clk_i);
    n_chk++; if (gnt_o !== 2'b10 || rvalid_o !== 2'b01) $display("FAIL t6_same gnt=%b rv=%b exp=10/01", gnt_o, rvalid_o); else n_pass++;
    next_cyc();
    set_in(2'b00, 1'b0, 1'b1, 32'h22);
    @(negedge clk_i);
    n_chk++; if (rvalid_o !== 2'b10) $display("FAIL t6_second got=%b exp=10", rvalid_o); else n_pass++;
    next_cyc();
    @(negedge clk_i);
    n_chk++; if (rvalid_o !== 2'b00) $display("FAIL t6_empty got=%b exp=00", rvalid_o); else n_pass++;
    next_cyc();
    set_in(2'b00, 1'b0, 1'b0, '0);
  endtask

  task automatic test_random();
    logic [1:0] r;
    apply_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      r = 2'($urandom_range(0, 3));
      if (lock) r[lock_idx] = 1'b1;   // requester holds its request until granted
      addr_i[0] = $urandom; addr_i[1] = $urandom;
      we_i = 2'($urandom); wdata_i[0] = $urandom; wdata_i[1] = $urandom;
      set_in(r, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom);
      @(negedge clk_i);
      model_eval();
      n_chk++; if (mem_req_o !== e_mreq) $display("FAIL rnd_mreq cyc=%0d got=%b exp=%b", c, mem_req_o, e_mreq); else n_pass++;
      n_chk++; if (gnt_o !== e_gnt) $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, gnt_o, e_gnt); else n_pass++;
      n_chk++; if (rvalid_o !== e_rv) $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, rvalid_o, e_rv); else n_pass++;
      n_chk++; if (err_o !== m_err) $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err_o, m_err); else n_pass++;
      if (e_mreq) begin
        n_chk++;
        if (mem_addr_o !== addr_i[e_sel] || mem_we_o !== we_i[e_sel] || mem_wdata_o !== wdata_i[e_sel])
          $display("FAIL rnd_payload cyc=%0d addr=%h exp=%h", c, mem_addr_o, addr_i[e_sel]);
        else n_pass++;
      end
      if (e_rv != 2'b00) begin
        n_chk++; if (rdata_o !== mem_rdata_i) $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, rdata_o, mem_rdata_i); else n_pass++;
      end
      model_update();
      next_cyc();
    end
  endtask

  initial begin
    addr_i[0] = 32'h100; addr_i[1] = 32'h200;
    we_i = 2'b00; be_i[0] = 4'hF; be_i[1] = 4'hF;
    wdata_i[0] = 32'h0; wdata_i[1] = 32'h0;
    set_in(2'b00, 1'b0, 1'b0, '0);
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_fifo_full();
    test_err_and_reset();
    test_push_pop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
